branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRIES, default 16: number of direct-mapped entries; power of two, 4..256.
REQ-002 Parameter TAG_BITS, default 8: stored tag width per entry.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1: reset, synchronous, active-high.
REQ-005 Port i_req_valid  in  1: fetch-stage lookup request.
REQ-006 Port i_req_pc  in  ADDR_WIDTH: fetch PC to look up.
REQ-007 Port o_req_hit  out  1: valid entry with matching tag.
REQ-008 Port o_req_prediction  out  BranchOutcome: TAKEN/NOT_TAKEN direction for the fetch PC.
REQ-009 Port o_req_target  out  ADDR_WIDTH: predicted target.
REQ-010 Port i_fb_valid  in  1: resolved conditional branch from EX.
REQ-011 Port i_fb_pc  in  ADDR_WIDTH: PC of the resolved branch.
REQ-012 Port i_fb_outcome  in  BranchOutcome: actual direction.
REQ-013 Port i_fb_target  in  ADDR_WIDTH: actual taken target.
REQ-014 Port i_inv_req  in  1: request to invalidate all entries.
REQ-015 Port o_inv_busy  out  1: invalidation sweep in progress.

Function
REQ-016 IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[IDX+TAG_BITS+1:IDX+2]; pc[1:0] ignored.
REQ-017 Each entry holds valid, tag, target (ADDR_WIDTH), 2-bit saturating counter.
REQ-018 Lookup is combinational, zero latency: o_req_hit = i_req_valid & entry.valid & tag match & ~o_inv_busy.
REQ-019 o_req_prediction = TAKEN iff o_req_hit and counter[1]=1, else NOT_TAKEN; o_req_target = entry target when o_req_hit, else 0.
REQ-020 Update, fb hit (valid, tag match): TAKEN -> counter +1 saturating at 2'b11, target <= i_fb_target; NOT_TAKEN -> counter -1 saturating at 2'b00, target unchanged.
REQ-021 Update, fb miss: TAKEN -> allocate (overwrite any occupant): valid=1, tag, target, counter=2'b10; NOT_TAKEN -> no change.
REQ-022 Lookup and update on the same index in the same cycle: lookup returns pre-update contents; update is visible from the next cycle.
REQ-023 FSM states IDLE, SWEEP; IDLE -> SWEEP when i_inv_req=1; SWEEP clears valid of entry sweep_ptr, one entry per cycle, sweep_ptr starting at 0; SWEEP -> IDLE in the cycle entry ENTRIES-1 is cleared.
REQ-024 o_inv_busy = 1 exactly in SWEEP: ENTRIES cycles after the request edge.
REQ-025 During SWEEP all feedback updates are dropped; i_inv_req is ignored.
REQ-026 Counter and target contents are not cleared by a sweep; only valid bits are cleared.

Reset
REQ-027 rst=1 at a clock edge: all valid bits = 0, all counters = 2'b01, FSM = IDLE, sweep_ptr = 0, statistics counters = 0; tags and targets need not be reset.
REQ-028 Reset asserted mid-sweep aborts the sweep; the cycle after, o_inv_busy=0 and all entries are invalid.
REQ-029 Reset has priority over feedback update and i_inv_req in the same cycle.

Configuration
REQ-030 Macro BTB_STATS_EN defined: adds outputs o_stat_lookups and o_stat_hits, 32 bits each; increment on each i_req_valid cycle and each o_req_hit cycle; saturate at 32'hFFFFFFFF.
REQ-031 Macro BTB_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.

Verification
REQ-032 After reset, lookup pc=0x0040_0010 -> o_req_hit=0, NOT_TAKEN, target=0.
REQ-033 fb pc=0x0040_0010 TAKEN target=0x0040_0100, then lookup of the same pc the next cycle -> hit=1, TAKEN, target=0x0040_0100.
REQ-034 Two NOT_TAKEN fb on pc=0x0040_0010 after REQ-033 -> counter 2'b10->2'b01->2'b00; lookup -> hit=1, NOT_TAKEN; third NOT_TAKEN keeps 2'b00.
REQ-035 Alias pc=0x0040_0050 (same index 4, different tag) TAKEN target=0x0040_0200 -> lookup of 0x0040_0010 misses; lookup of 0x0040_0050 hits with 0x0040_0200.
REQ-036 i_inv_req pulse with ENTRIES=16 -> o_inv_busy high 16 cycles; fb TAKEN during the sweep is dropped; all lookups miss afterwards.
REQ-037 Same-cycle lookup and allocate of pc=0x0040_0020 -> miss that cycle, hit the next cycle; rst asserted at sweep cycle 5 -> o_inv_busy=0 the next cycle.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters and a one-entry-per-cycle invalidation sweep.
// Outcome encoding: TAKEN = 1'b1, NOT_TAKEN = 1'b0. Define BTB_STATS_EN to add lookup/hit counters.
module branch_target_buffer #(
   parameter int unsigned ENTRIES    = 16,
   parameter int unsigned TAG_BITS   = 8,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   output logic                  o_req_hit,
   output logic                  o_req_prediction,
   output logic [ADDR_WIDTH-1:0] o_req_target,
   input  logic                  i_fb_valid,
   input  logic [ADDR_WIDTH-1:0] i_fb_pc,
   input  logic                  i_fb_outcome,
   input  logic [ADDR_WIDTH-1:0] i_fb_target,
   input  logic                  i_inv_req,
`ifdef BTB_STATS_EN
   output logic [31:0]           o_stat_lookups,
   output logic [31:0]           o_stat_hits,
`endif
   output logic                  o_inv_busy
);
   localparam int unsigned IDX = $clog2(ENTRIES);
   localparam logic TAKEN = 1'b1;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e                state_q, state_d;
   logic [IDX-1:0]        sweep_ptr_q, sweep_ptr_d;
   logic [ENTRIES-1:0]    valid_q;
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];

   logic [IDX-1:0]      req_idx, fb_idx;
   logic [TAG_BITS-1:0] req_tag, fb_tag;
   logic                fb_hit, fb_upd;
   logic [1:0]          ctr_cur, ctr_nxt;

   // Bits outside index/tag fields are intentionally ignored.
   logic unused_pc;
   assign unused_pc = ^{i_req_pc, i_fb_pc};

   assign req_idx = i_req_pc[IDX+1:2];
   assign req_tag = i_req_pc[IDX+TAG_BITS+1:IDX+2];
   assign fb_idx  = i_fb_pc[IDX+1:2];
   assign fb_tag  = i_fb_pc[IDX+TAG_BITS+1:IDX+2];

   assign o_inv_busy       = (state_q == SWEEP);
   assign o_req_hit        = i_req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                             && !o_inv_busy;
   assign o_req_prediction = o_req_hit && ctr_q[req_idx][1];
   assign o_req_target     = o_req_hit ? target_q[req_idx] : '0;

   always_comb begin
      fb_hit  = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
      fb_upd  = i_fb_valid && (state_q == IDLE);
      ctr_cur = ctr_q[fb_idx];
      ctr_nxt = ctr_cur;
      if (i_fb_outcome == TAKEN) begin
         if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
      end else if (ctr_cur != 2'b00) begin
         ctr_nxt = ctr_cur - 2'b01;
      end
   end

   always_comb begin
      state_d     = state_q;
      sweep_ptr_d = sweep_ptr_q;
      case (state_q)
         IDLE: begin
            if (i_inv_req) begin
               state_d     = SWEEP;
               sweep_ptr_d = '0;
            end
         end
         SWEEP: begin
            sweep_ptr_d = sweep_ptr_q + IDX'(1);
            if (sweep_ptr_q == IDX'(ENTRIES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sweep_ptr_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_ptr_q <= sweep_ptr_d;
      end
   end

   // Sweep clears only valid bits; counters survive until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= 2'b01;
      end else if (state_q == SWEEP) begin
         valid_q[sweep_ptr_q] <= 1'b0;
      end else if (fb_upd) begin
         if (fb_hit) begin
            ctr_q[fb_idx] <= ctr_nxt;
         end else if (i_fb_outcome == TAKEN) begin
            valid_q[fb_idx] <= 1'b1;
            ctr_q[fb_idx]   <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && fb_upd && (i_fb_outcome == TAKEN)) begin
         tag_q[fb_idx]    <= fb_tag;
         target_q[fb_idx] <= i_fb_target;
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] lookups_q, hits_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lookups_q <= '0;
         hits_q    <= '0;
      end else begin
         if (i_req_valid && (lookups_q != 32'hFFFF_FFFF)) lookups_q <= lookups_q + 32'd1;
         if (o_req_hit && (hits_q != 32'hFFFF_FFFF))      hits_q    <= hits_q + 32'd1;
      end
   end

   assign o_stat_lookups = lookups_q;
   assign o_stat_hits    = hits_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, sweep/reset sequences,
// and randomized traffic checked against an array-based reference model.
module tb_branch_target_buffer;
   localparam int unsigned ENTRIES    = 16;
   localparam int unsigned TAG_BITS   = 8;
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned IDXB       = $clog2(ENTRIES);

   logic                  clk;
   logic                  rst;
   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic                  req_hit;
   logic                  req_pred;
   logic [ADDR_WIDTH-1:0] req_target;
   logic                  fb_valid;
   logic [ADDR_WIDTH-1:0] fb_pc;
   logic                  fb_outcome;
   logic [ADDR_WIDTH-1:0] fb_target;
   logic                  inv_req;
   logic                  inv_busy;
`ifdef BTB_STATS_EN
   logic [31:0]           stat_lookups;
   logic [31:0]           stat_hits;
`endif

   branch_target_buffer #(
      .ENTRIES    (ENTRIES),
      .TAG_BITS   (TAG_BITS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_req_valid      (req_valid),
      .i_req_pc         (req_pc),
      .o_req_hit        (req_hit),
      .o_req_prediction (req_pred),
      .o_req_target     (req_target),
      .i_fb_valid       (fb_valid),
      .i_fb_pc          (fb_pc),
      .i_fb_outcome     (fb_outcome),
      .i_fb_target      (fb_target),
      .i_inv_req        (inv_req),
`ifdef BTB_STATS_EN
      .o_stat_lookups   (stat_lookups),
      .o_stat_hits      (stat_hits),
`endif
      .o_inv_busy       (inv_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit          m_valid  [ENTRIES];
   int          m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int          m_sweep_left = 0;
   logic [31:0] m_lookups = '0;
   logic [31:0] m_hits    = '0;

   function automatic int pc_idx(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int pc_tag(input logic [31:0] pc);
      return int'((pc >> (IDXB + 2)) % (1 << TAG_BITS));
   endfunction

   function automatic void model_lookup(input logic [31:0] pc, input logic v, output logic hit,
                                        output logic pred, output logic [31:0] tgt);
      int i;
      i    = pc_idx(pc);
      hit  = v && (m_sweep_left == 0) && m_valid[i] && (m_tag[i] == pc_tag(pc));
      pred = hit && (m_ctr[i] >= 2);
      tgt  = hit ? m_target[i] : 32'h0;
   endfunction

   function automatic void model_edge();
      logic h, p;
      logic [31:0] t;
      int i;
      model_lookup(req_pc, req_valid, h, p, t);
      if (rst) begin
         for (int k = 0; k < int'(ENTRIES); k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 1;
         end
         m_sweep_left = 0;
         m_lookups    = '0;
         m_hits       = '0;
         return;
      end
      if (req_valid && m_lookups != 32'hFFFF_FFFF) m_lookups = m_lookups + 1;
      if (h && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
      if (m_sweep_left > 0) begin
         m_valid[int'(ENTRIES) - m_sweep_left] = 1'b0;
         m_sweep_left--;
      end else begin
         if (fb_valid) begin
            i = pc_idx(fb_pc);
            if (m_valid[i] && m_tag[i] == pc_tag(fb_pc)) begin
               if (fb_outcome) begin
                  m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                  m_target[i] = fb_target;
               end else begin
                  m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
               end
            end else if (fb_outcome) begin
               m_valid[i]  = 1'b1;
               m_tag[i]    = pc_tag(fb_pc);
               m_target[i] = fb_target;
               m_ctr[i]    = 2;
            end
         end
         if (inv_req) m_sweep_left = int'(ENTRIES);
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic fv,
                        input logic [31:0] fpc, input logic fo, input logic [31:0] ft,
                        input logic inv);
      rst        = r;
      req_valid  = rv;
      req_pc     = rpc;
      fb_valid   = fv;
      fb_pc      = fpc;
      fb_outcome = fo;
      fb_target  = ft;
      inv_req    = inv;
   endtask

   // Outputs are sampled 1 time unit after inputs change, well clear of the rising edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct packed {
      logic        req_valid;
      logic [31:0] req_pc;
      logic        fb_valid;
      logic [31:0] fb_pc;
      logic        fb_outcome;
      logic [31:0] fb_target;
      logic        inv;
      logic        exp_hit;
      logic        exp_pred;
      logic [31:0] exp_target;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic rv, input logic [31:0] rpc, input logic fv,
                                   input logic [31:0] fpc, input logic fo, input logic [31:0] ft,
                                   input logic inv, input logic eh, input logic ep,
                                   input logic [31:0] et);
      vec_t v;
      v.req_valid  = rv;
      v.req_pc     = rpc;
      v.fb_valid   = fv;
      v.fb_pc      = fpc;
      v.fb_outcome = fo;
      v.fb_target  = ft;
      v.inv        = inv;
      v.exp_hit    = eh;
      v.exp_pred   = ep;
      v.exp_target = et;
      vecs.push_back(v);
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = 32'h0040_0000 | ($urandom_range(3) << (IDXB + 2)) | ($urandom_range(ENTRIES - 1) << 2)
          | $urandom_range(3);
      return p;
   endfunction

   initial begin
      logic        e_hit, e_pred;
      logic [31:0] e_tgt;
      logic [31:0] probe [4];

      //       req_v req_pc        fb_v fb_pc         out  fb_target     inv hit pred target
      add_vec(1, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0);
      add_vec(0, 32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0100, 0, 0, 0, 32'h0);
      add_vec(1, 32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0,         0, 1, 1, 32'h0040_0100);
      add_vec(1, 32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0,         0, 1, 0, 32'h0040_0100);
      add_vec(1, 32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0,         0, 1, 0, 32'h0040_0100);
      add_vec(1, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         0, 1, 0, 32'h0040_0100);
      add_vec(1, 32'h0040_0010, 1, 32'h0040_0050, 1, 32'h0040_0200, 0, 1, 0, 32'h0040_0100);
      add_vec(1, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0);
      add_vec(1, 32'h0040_0050, 0, 32'h0,         0, 32'h0,         0, 1, 1, 32'h0040_0200);
      add_vec(1, 32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0300, 0, 0, 0, 32'h0);
      add_vec(1, 32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0304, 0, 1, 1, 32'h0040_0300);
      add_vec(1, 32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0308, 0, 1, 1, 32'h0040_0304);
      add_vec(1, 32'h0040_0020, 1, 32'h0040_0020, 0, 32'h0,         0, 1, 1, 32'h0040_0308);
      add_vec(1, 32'h0040_0020, 0, 32'h0,         0, 32'h0,         0, 1, 1, 32'h0040_0308);
      add_vec(1, 32'h0040_0050, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0040_0200);

      drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      @(posedge clk);
      #1;
      tick();
      tick();
      drive(0, 1, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 0);
      #1;
      check("reset_busy", inv_busy, 0);

      foreach (vecs[i]) begin
         drive(0, vecs[i].req_valid, vecs[i].req_pc, vecs[i].fb_valid, vecs[i].fb_pc,
               vecs[i].fb_outcome, vecs[i].fb_target, vecs[i].inv);
         #1;
         check($sformatf("vec%0d_hit", i), req_hit, vecs[i].exp_hit);
         check($sformatf("vec%0d_pred", i), req_pred, vecs[i].exp_pred);
         check($sformatf("vec%0d_target", i), req_target, vecs[i].exp_target);
         check($sformatf("vec%0d_busy", i), inv_busy, 0);
         tick();
      end

      // Sweep: feedback and repeated requests during it must be ignored.
      for (int c = 0; c < int'(ENTRIES); c++) begin
         drive(0, 1, 32'h0040_0050, 1, 32'h0040_0060, 1, 32'h0040_0600, 1);
         #1;
         check($sformatf("sweep%0d_busy", c), inv_busy, 1);
         check($sformatf("sweep%0d_hit", c), req_hit, 0);
         tick();
      end
      probe[0] = 32'h0040_0010;
      probe[1] = 32'h0040_0050;
      probe[2] = 32'h0040_0020;
      probe[3] = 32'h0040_0060;
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, probe[k], 0, 32'h0, 0, 32'h0, 0);
         #1;
         check($sformatf("post_sweep%0d_busy", k), inv_busy, 0);
         check($sformatf("post_sweep%0d_hit", k), req_hit, 0);
         tick();
      end

      // Reset in the middle of a sweep, with feedback and invalidate also asserted.
      drive(0, 0, 32'h0, 1, 32'h0040_003C, 1, 32'h0040_0400, 0);
      tick();
      drive(0, 1, 32'h0040_003C, 0, 32'h0, 0, 32'h0, 1);
      #1;
      check("pre_abort_hit", req_hit, 1);
      check("pre_abort_target", req_target, 32'h0040_0400);
      tick();
      for (int c = 1; c <= 5; c++) begin
         drive(c == 5, 0, 32'h0, c == 5, 32'h0040_0010, 1, 32'h0040_0700, 1);
         #1;
         check($sformatf("abort_sweep%0d_busy", c), inv_busy, 1);
         tick();
      end
      drive(0, 1, 32'h0040_003C, 0, 32'h0, 0, 32'h0, 0);
      #1;
      check("abort_busy", inv_busy, 0);
      check("abort_hi_entry_hit", req_hit, 0);
      tick();
      drive(0, 1, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 0);
      #1;
      check("abort_fb_dropped_hit", req_hit, 0);
      check("abort_busy2", inv_busy, 0);
      tick();

      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(299) == 0), 1'($urandom_range(3) != 0), rand_pc(),
               1'($urandom_range(1)), rand_pc(), 1'($urandom_range(1)),
               $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(79) == 0));
         #1;
         model_lookup(req_pc, req_valid, e_hit, e_pred, e_tgt);
         check("rand_hit", req_hit, e_hit);
         check("rand_pred", req_pred, e_pred);
         check("rand_target", req_target, e_tgt);
         check("rand_busy", inv_busy, m_sweep_left > 0);
`ifdef BTB_STATS_EN
         check("rand_stat_lookups", stat_lookups, m_lookups);
         check("rand_stat_hits", stat_hits, m_hits);
`endif
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
